key_entry_buf: RTL

Keypad entry buffer placed between the matrix key scanner and the 8-digit seven-segment driver. It consumes the scanner's held key-valid/key-code pair and acts once per press, with auto-repeat on held digit keys. It maintains an 8-digit right-aligned BCD entry field with backspace, clear and enter editing. It drives the 32-bit BCD word to the display and latches the completed entry on enter.

---
 rtl/key_entry_buf.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/key_entry_buf.sv
// Keypad entry buffer: turns held scanner key reports into one edit action per press,
// with auto-repeat on held digits, and keeps an 8-digit right-aligned BCD entry field.
module key_entry_buf #(
  parameter int          HOLD_MS = 500,
  parameter int          RPT_MS  = 100,
  parameter logic [3:0]  BLANK   = 4'hF
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_pls_1k,
  input  logic        i_key_valid,
  input  logic [4:0]  i_key_value,
  output logic [31:0] o_bcd8d,
  output logic [3:0]  o_digit_cnt,
  output logic [31:0] o_entry,
  output logic        o_enter,
  output logic        o_err,
  output logic [1:0]  o_state
);

  localparam int CNT_MAX = (HOLD_MS > RPT_MS) ? HOLD_MS : RPT_MS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_T = CW'(HOLD_MS);
  localparam logic [CW-1:0] RPT_T  = CW'(RPT_MS);
  localparam logic [CW-1:0] SAT_T  = CW'(CNT_MAX);
  localparam logic [31:0]   BLANK_WORD = {8{BLANK}};

  localparam logic [4:0] KEY_BKSP  = 5'd10;
  localparam logic [4:0] KEY_CLEAR = 5'd11;
  localparam logic [4:0] KEY_ENTER = 5'd12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [4:0]    code, code_nxt;
  logic [CW-1:0] tick_cnt, tick_nxt, tick_inc;
  logic          act;
  logic [4:0]    act_code;

  assign o_state  = state;
  assign tick_inc = (tick_cnt == SAT_T) ? tick_cnt : tick_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      code     <= '0;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      code     <= code_nxt;
      tick_cnt <= tick_nxt;
    end
  end

  // Press edge acts immediately; only digit codes re-fire while held.
  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    tick_nxt  = tick_cnt;
    act       = 1'b0;
    act_code  = code;
    case (state)
      IDLE: begin
        if (i_key_valid) begin
          act       = 1'b1;
          act_code  = i_key_value;
          code_nxt  = i_key_value;
          tick_nxt  = '0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!i_key_valid) begin
          tick_nxt  = '0;
          state_nxt = IDLE;
        end else if (i_pls_1k) begin
          tick_nxt = tick_inc;
          if (tick_inc == HOLD_T && code < 5'd10) begin
            act       = 1'b1;
            tick_nxt  = '0;
            state_nxt = REPEAT;
          end
        end
      end
      REPEAT: begin
        if (!i_key_valid) begin
          tick_nxt  = '0;
          state_nxt = IDLE;
        end else if (i_pls_1k) begin
          tick_nxt = tick_inc;
          if (tick_inc == RPT_T) begin
            act      = 1'b1;
            tick_nxt = '0;
          end
        end
      end
      default: begin
        tick_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_bcd8d     <= BLANK_WORD;
      o_entry     <= BLANK_WORD;
      o_digit_cnt <= '0;
      o_enter     <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_enter <= 1'b0;
      o_err   <= 1'b0;
      if (act) begin
        if (act_code < 5'd10) begin
          if (o_digit_cnt < 4'd8) begin
            o_bcd8d     <= {o_bcd8d[27:0], act_code[3:0]};
            o_digit_cnt <= o_digit_cnt + 4'd1;
          end else begin
            o_err <= 1'b1;
          end
        end else begin
          case (act_code)
            KEY_BKSP: begin
              if (o_digit_cnt != 4'd0) begin
                o_bcd8d     <= {BLANK, o_bcd8d[31:4]};
                o_digit_cnt <= o_digit_cnt - 4'd1;
              end else begin
                o_err <= 1'b1;
              end
            end
            KEY_CLEAR: begin
              o_bcd8d     <= BLANK_WORD;
              o_digit_cnt <= '0;
            end
            KEY_ENTER: begin
              if (o_digit_cnt != 4'd0) begin
                o_entry     <= o_bcd8d;
                o_enter     <= 1'b1;
                o_bcd8d     <= BLANK_WORD;
                o_digit_cnt <= '0;
              end else begin
                o_err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
